// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a 1/10/100/1000 ms gate
// and reports Hz (saturated), with running min/max of the reported values.
module freq_meter #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_FREQ    = 999_999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  input  logic        enable,
  input  logic [1:0]  gate_sel,
  input  logic        clr_minmax,
  output logic [19:0] freq_hz,
  output logic        freq_valid,
  output logic        overrange,
  output logic [19:0] freq_min,
  output logic [19:0] freq_max,
  output logic        busy
);

  localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;
  localparam int unsigned CYC_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(CYC_PER_MS - 1);
  localparam logic [23:0]      CNT_MAX    = 24'hFFFFFF;
  localparam logic [33:0]      MAX_FREQ_W = 34'(MAX_FREQ);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_GATE = 1'b1
  } state_t;

  // Index of the final millisecond for each gate setting.
  function automatic logic [9:0] ms_last(input logic [1:0] g);
    logic [9:0] v;
    case (g)
      2'b00:   v = 10'd0;
      2'b01:   v = 10'd9;
      2'b10:   v = 10'd99;
      2'b11:   v = 10'd999;
      default: v = 10'd0;
    endcase
    return v;
  endfunction

  // Count to Hz: multiply by 1000/100/10/1 using shifts and adds only.
  function automatic logic [33:0] scale(input logic [23:0] c, input logic [1:0] g);
    logic [33:0] w;
    logic [33:0] v;
    w = {10'd0, c};
    case (g)
      2'b00:   v = (w << 10) - (w << 4) - (w << 3);
      2'b01:   v = (w << 6) + (w << 5) + (w << 2);
      2'b10:   v = (w << 3) + (w << 1);
      2'b11:   v = w;
      default: v = w;
    endcase
    return v;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic                   r_edge;

  state_t           r_state;
  logic             r_busy;
  logic [1:0]       r_gate;
  logic [CYC_W-1:0] r_cyc;
  logic [9:0]       r_ms;
  logic [23:0]      r_edge_cnt;

  logic [23:0] r_cnt_snap;
  logic [1:0]  r_gate_snap;
  logic        r_snap_vld;
  logic [33:0] r_scaled;
  logic        r_p1_vld;

  logic [19:0] r_freq_hz;
  logic        r_freq_valid;
  logic        r_overrange;
  logic [19:0] r_min;
  logic [19:0] r_max;

  logic [23:0] w_cnt_next;
  logic        w_last;
  logic [19:0] w_new;
  logic        w_ovr;

  // Synchronizer chain and registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
      r_edge      <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
      r_edge      <= r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    end
  end

  // Saturating edge count including this cycle's pulse, and end-of-window detect.
  always_comb begin
    w_cnt_next = r_edge_cnt;
    if (r_edge && (r_edge_cnt != CNT_MAX)) begin
      w_cnt_next = r_edge_cnt + 24'd1;
    end else begin
      w_cnt_next = r_edge_cnt;
    end
    w_last = (r_cyc == CYC_LAST) && (r_ms == ms_last(r_gate));
  end

  // Gate FSM: windows run back-to-back while enabled; dropping enable mid-window discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_gate      <= 2'b00;
      r_cyc       <= '0;
      r_ms        <= 10'd0;
      r_edge_cnt  <= 24'd0;
      r_cnt_snap  <= 24'd0;
      r_gate_snap <= 2'b00;
      r_snap_vld  <= 1'b0;
    end else begin
      r_snap_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_gate     <= gate_sel;
            r_edge_cnt <= 24'd0;
            r_cyc      <= '0;
            r_ms       <= 10'd0;
            r_busy     <= 1'b1;
            r_state    <= S_GATE;
          end
        end
        S_GATE: begin
          if (w_last) begin
            r_cnt_snap  <= w_cnt_next;
            r_gate_snap <= r_gate;
            r_snap_vld  <= 1'b1;
            r_edge_cnt  <= 24'd0;
            r_cyc       <= '0;
            r_ms        <= 10'd0;
            if (enable) begin
              r_gate <= gate_sel;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (!enable) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_edge_cnt <= w_cnt_next;
            if (r_cyc == CYC_LAST) begin
              r_cyc <= '0;
              r_ms  <= r_ms + 10'd1;
            end else begin
              r_cyc <= r_cyc + CYC_W'(1);
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // P1: scale the snapshot count to Hz.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scaled <= 34'd0;
      r_p1_vld <= 1'b0;
    end else begin
      r_p1_vld <= r_snap_vld;
      if (r_snap_vld) begin
        r_scaled <= scale(r_cnt_snap, r_gate_snap);
      end
    end
  end

  // Saturation of the scaled value.
  always_comb begin
    w_new = r_scaled[19:0];
    w_ovr = 1'b0;
    if (r_scaled > MAX_FREQ_W) begin
      w_new = MAX_FREQ_W[19:0];
      w_ovr = 1'b1;
    end else begin
      w_new = r_scaled[19:0];
      w_ovr = 1'b0;
    end
  end

  // P2: publish result and update min/max; a coincident clear restarts tracking from the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq_hz    <= 20'd0;
      r_freq_valid <= 1'b0;
      r_overrange  <= 1'b0;
      r_min        <= 20'hFFFFF;
      r_max        <= 20'd0;
    end else begin
      r_freq_valid <= r_p1_vld;
      if (r_p1_vld) begin
        r_freq_hz   <= w_new;
        r_overrange <= w_ovr;
        if (clr_minmax) begin
          r_min <= w_new;
          r_max <= w_new;
        end else begin
          if (w_new < r_min) r_min <= w_new;
          if (w_new > r_max) r_max <= w_new;
        end
      end else if (clr_minmax) begin
        r_min <= 20'hFFFFF;
        r_max <= 20'd0;
      end
    end
  end

  assign freq_hz    = r_freq_hz;
  assign freq_valid = r_freq_valid;
  assign overrange  = r_overrange;
  assign freq_min   = r_min;
  assign freq_max   = r_max;
  assign busy       = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: 1 MHz-clock instance for most scenarios, 4 MHz-clock instance for overrange.
module tb_freq_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable;
  logic [1:0]  gate_sel;
  logic        clr_minmax;
  logic [19:0] freq_hz, freq_min, freq_max;
  logic        freq_valid, overrange, busy;

  logic        enable2;
  logic [1:0]  gate_sel2;
  logic        clr2;
  logic [19:0] f2_hz, f2_min, f2_max;
  logic        f2_valid, f2_over, f2_busy;

  // Phase-accumulator square wave: exact edge counts over whole windows.
  int   gen_inc = 0;
  int   gen_mod = 1_000_000;
  int   acc = 0;
  logic gen_on = 1'b0;
  logic sig_gen = 1'b0;
  logic sig_man = 1'b0;
  logic sig_in;
  assign sig_in = gen_on ? sig_gen : sig_man;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (gen_inc != 0) begin
        acc = acc + gen_inc;
        if (acc >= gen_mod) begin
          acc     = acc - gen_mod;
          sig_gen = ~sig_gen;
        end
      end
    end
  end

  freq_meter #(.CLK_HZ(1_000_000)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable), .gate_sel(gate_sel),
    .clr_minmax(clr_minmax), .freq_hz(freq_hz), .freq_valid(freq_valid),
    .overrange(overrange), .freq_min(freq_min), .freq_max(freq_max), .busy(busy)
  );

  freq_meter #(.CLK_HZ(4_000_000)) dut2 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable2), .gate_sel(gate_sel2),
    .clr_minmax(clr2), .freq_hz(f2_hz), .freq_valid(f2_valid),
    .overrange(f2_over), .freq_min(f2_min), .freq_max(f2_max), .busy(f2_busy)
  );

  typedef struct {
    logic [19:0] f;
    logic        o;
    logic [19:0] mn;
    logic [19:0] mx;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic set_gen(input int f);
    gen_inc = 2 * f;
    gen_on  = (f != 0);
  endtask

  task automatic push_exp(input logic [19:0] f, input logic o, input logic [19:0] mn,
                          input logic [19:0] mx);
    exp_t e;
    e.f = f; e.o = o; e.mn = mn; e.mx = mx;
    sb.push_back(e);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy) break;
    end
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!freq_valid && cyc < budget);
    if (!freq_valid) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; enable2 = 1'b0; gate_sel = 2'b00; gate_sel2 = 2'b00;
    clr_minmax = 1'b0; clr2 = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({freq_hz, freq_valid, overrange, freq_min, freq_max, busy} !==
        {20'd0, 1'b0, 1'b0, 20'hFFFFF, 20'd0, 1'b0})
      $display("FAIL reset_dut: hz=%0d v=%0b ovr=%0b min=%h max=%0d busy=%0b", freq_hz,
               freq_valid, overrange, freq_min, freq_max, busy);
    else n_pass++;
    n_chk++;
    if ({f2_hz, f2_valid, f2_over, f2_min, f2_max, f2_busy} !==
        {20'd0, 1'b0, 1'b0, 20'hFFFFF, 20'd0, 1'b0})
      $display("FAIL reset_dut2: hz=%0d v=%0b ovr=%0b min=%h max=%0d busy=%0b", f2_hz,
               f2_valid, f2_over, f2_min, f2_max, f2_busy);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One isolated measurement window, result checked against the scoreboard.
  task automatic run_window(input string nm, input int f, input logic [1:0] g,
                            input logic [19:0] ef, input logic eo, input logic [19:0] emn,
                            input logic [19:0] emx);
    int   cyc;
    exp_t e;
    enable = 1'b0;
    set_gen(f);
    repeat (6) @(negedge clk);
    gate_sel = g;
    push_exp(ef, eo, emn, emx);
    enable = 1'b1;
    wait_valid(1100, cyc);
    e = sb.pop_front();
    n_chk++;
    if (cyc < 0) $display("FAIL %s: no freq_valid within budget", nm);
    else if ({freq_hz, overrange, freq_min, freq_max} !== {e.f, e.o, e.mn, e.mx})
      $display("FAIL %s: got hz=%0d ovr=%0b min=%0d max=%0d, want hz=%0d ovr=%0b min=%0d max=%0d",
               nm, freq_hz, overrange, freq_min, freq_max, e.f, e.o, e.mn, e.mx);
    else n_pass++;
    enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_basic();
    int   cyc;
    exp_t e;
    set_gen(10000);
    repeat (6) @(negedge clk);
    gate_sel = 2'b00;
    for (int i = 0; i < 3; i++) push_exp(20'd10000, 1'b0, 20'd10000, 20'd10000);
    enable = 1'b1;
    wait_busy();
    n_chk++;
    if (busy !== 1'b1) $display("FAIL t1_busy: busy=%0b want 1", busy);
    else n_pass++;
    for (int w = 0; w < 3; w++) begin
      wait_valid(1100, cyc);
      e = sb.pop_front();
      n_chk++;
      if (cyc !== ((w == 0) ? 1002 : 1000))
        $display("FAIL t1_latency[%0d]: got %0d cycles want %0d", w, cyc, (w == 0) ? 1002 : 1000);
      else n_pass++;
      n_chk++;
      if ({freq_hz, overrange, freq_min, freq_max} !== {e.f, e.o, e.mn, e.mx})
        $display("FAIL t1_result[%0d]: got hz=%0d ovr=%0b min=%0d max=%0d want hz=%0d ovr=%0b min=%0d max=%0d",
                 w, freq_hz, overrange, freq_min, freq_max, e.f, e.o, e.mn, e.mx);
      else n_pass++;
    end
    enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_gate_change();
    int   cyc;
    exp_t e;
    set_gen(2500);
    repeat (6) @(negedge clk);
    gate_sel = 2'b01;
    push_exp(20'd2500, 1'b0, 20'd2500, 20'd10000);
    enable = 1'b1;
    wait_busy();
    repeat (3000) @(negedge clk);
    gate_sel = 2'b00;
    wait_valid(7100, cyc);
    e = sb.pop_front();
    n_chk++;
    if (cyc < 0 || cyc + 3000 !== 10002)
      $display("FAIL t2_window_len: got %0d cycles want 10002", cyc + 3000);
    else n_pass++;
    n_chk++;
    if ({freq_hz, overrange, freq_min, freq_max} !== {e.f, e.o, e.mn, e.mx})
      $display("FAIL t2_result: got hz=%0d ovr=%0b min=%0d max=%0d want hz=%0d ovr=%0b min=%0d max=%0d",
               freq_hz, overrange, freq_min, freq_max, e.f, e.o, e.mn, e.mx);
    else n_pass++;
    wait_valid(1100, cyc);
    n_chk++;
    if (cyc !== 1000) $display("FAIL t2_next_len: got %0d cycles want 1000", cyc);
    else n_pass++;
    n_chk++;
    if (freq_hz !== 20'd2000 && freq_hz !== 20'd3000)
      $display("FAIL t2_next_hz: got %0d want 2000 or 3000", freq_hz);
    else n_pass++;
    enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_clear_alone(input string nm);
    clr_minmax = 1'b1;
    @(negedge clk);
    clr_minmax = 1'b0;
    n_chk++;
    if ({freq_min, freq_max} !== {20'hFFFFF, 20'd0})
      $display("FAIL %s: got min=%h max=%0d want min=fffff max=0", nm, freq_min, freq_max);
    else n_pass++;
  endtask

  task automatic test_overrange();
    int cyc;
    test_clear_alone("t3_clear");
    run_window("t3_250k", 250000, 2'b00, 20'd250000, 1'b0, 20'd250000, 20'd250000);
    set_gen(250000);
    repeat (6) @(negedge clk);
    enable2 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!f2_valid && cyc < 4100);
    n_chk++;
    if (!f2_valid) $display("FAIL t3_ovr_timeout: no freq_valid on 4 MHz instance");
    else if ({f2_hz, f2_over, f2_min, f2_max} !== {20'd999999, 1'b1, 20'd999999, 20'd999999})
      $display("FAIL t3_ovr: got hz=%0d ovr=%0b min=%0d max=%0d want hz=999999 ovr=1 min=999999 max=999999",
               f2_hz, f2_over, f2_min, f2_max);
    else n_pass++;
    enable2 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_minmax();
    int   cyc;
    exp_t e;
    test_clear_alone("t4_clear");
    run_window("t4_5k", 5000, 2'b00, 20'd5000, 1'b0, 20'd5000, 20'd5000);
    run_window("t4_15k", 15000, 2'b00, 20'd15000, 1'b0, 20'd5000, 20'd15000);
    set_gen(8000);
    repeat (6) @(negedge clk);
    gate_sel = 2'b00;
    push_exp(20'd8000, 1'b0, 20'd5000, 20'd15000);
    push_exp(20'd8000, 1'b0, 20'd8000, 20'd8000);
    enable = 1'b1;
    wait_valid(1100, cyc);
    e = sb.pop_front();
    n_chk++;
    if (cyc < 0 || {freq_hz, overrange, freq_min, freq_max} !== {e.f, e.o, e.mn, e.mx})
      $display("FAIL t4_8k: got hz=%0d ovr=%0b min=%0d max=%0d want hz=%0d ovr=%0b min=%0d max=%0d",
               freq_hz, overrange, freq_min, freq_max, e.f, e.o, e.mn, e.mx);
    else n_pass++;
    repeat (999) @(negedge clk);
    clr_minmax = 1'b1;
    @(negedge clk);
    clr_minmax = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if ({freq_valid, freq_hz, freq_min, freq_max} !== {1'b1, e.f, e.mn, e.mx})
      $display("FAIL t4_clr_coincident: got v=%0b hz=%0d min=%0d max=%0d want v=1 hz=%0d min=%0d max=%0d",
               freq_valid, freq_hz, freq_min, freq_max, e.f, e.mn, e.mx);
    else n_pass++;
    enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int   cyc;
    int   sum;
    exp_t e;
    set_gen(0);
    sig_man = 1'b0;
    repeat (6) @(negedge clk);
    gate_sel = 2'b00;
    push_exp(20'd4000, 1'b0, 20'd4000, 20'd8000);
    push_exp(20'd1000, 1'b0, 20'd1000, 20'd8000);
    enable = 1'b1;
    wait_busy();
    // Three mid-window pulses, one whose edge pulse lands on the last gate cycle, one just after.
    for (int k = 1; k <= 1001; k++) begin
      @(negedge clk);
      sig_man = ((k >= 100 && k < 110) || (k >= 200 && k < 210) || (k >= 300 && k < 310) ||
                 k == 996 || k == 997 || k >= 999);
    end
    for (int w = 0; w < 2; w++) begin
      wait_valid(1100, cyc);
      e = sb.pop_front();
      n_chk++;
      if (cyc < 0 || {freq_hz, overrange, freq_min, freq_max} !== {e.f, e.o, e.mn, e.mx})
        $display("FAIL t5_last_edge[%0d]: got hz=%0d min=%0d max=%0d want hz=%0d min=%0d max=%0d",
                 w, freq_hz, freq_min, freq_max, e.f, e.mn, e.mx);
      else n_pass++;
    end
    enable = 1'b0;
    repeat (6) @(negedge clk);
    sig_man = 1'b0;
    set_gen(7300);
    repeat (6) @(negedge clk);
    enable = 1'b1;
    sum = 0;
    for (int w = 0; w < 10; w++) begin
      wait_valid(1100, cyc);
      if (cyc < 0) break;
      sum = sum + int'(freq_hz);
    end
    n_chk++;
    if (sum !== 73000) $display("FAIL t5_no_loss: 10-window sum got %0d want 73000", sum);
    else n_pass++;
    enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_abort();
    int nvalid;
    set_gen(10000);
    repeat (6) @(negedge clk);
    gate_sel = 2'b00;
    enable = 1'b1;
    wait_busy();
    repeat (500) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL t6_busy_drop: busy=%0b want 0", busy);
    else n_pass++;
    nvalid = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (freq_valid) nvalid++;
    end
    n_chk++;
    if (nvalid !== 0) $display("FAIL t6_no_valid: got %0d pulses want 0", nvalid);
    else n_pass++;
    enable = 1'b1;
    wait_busy();
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({freq_hz, freq_valid, overrange, freq_min, freq_max, busy} !==
        {20'd0, 1'b0, 1'b0, 20'hFFFFF, 20'd0, 1'b0})
      $display("FAIL t6_async_reset: hz=%0d v=%0b ovr=%0b min=%h max=%0d busy=%0b", freq_hz,
               freq_valid, overrange, freq_min, freq_max, busy);
    else n_pass++;
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gate_change();
    test_overrange();
    test_minmax();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
